spi_clkgen: RTL and testbench
=============================

Name: spi_clkgen

Overview:
Parametrised SPI serial-clock generator, the successor to the fixed 16-bit prescaler. It adds three things the prescaler lacks: configurable divider width, CPOL/CPHA mode support, and burst framing of N bits with a start/busy/done/abort handshake. It sits between the register front-end and the SPI shift engine, and provides SCLK plus per-edge sample and shift strobes.

Parameters:
DIV_W, 16, width of the half-period divider value
BITS_W, 6, width of the bit-count input (max burst = 2^BITS_W-1 bits)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
div_stb_i  in  1  load strobe for div_i
div_i  in  DIV_W  half-period divider; half-period = div+1 clk_i cycles
cpol_i  in  1  clock polarity (idle level of sclk_o)
cpha_i  in  1  clock phase (0: sample on leading edge, 1: shift on leading edge)
nb_bits_i  in  BITS_W  number of bits in burst
start_i  in  1  start a burst (single-cycle strobe)
abort_i  in  1  abort the current burst
sclk_o  out  1  serial clock
sample_o  out  1  1-cycle strobe on each sampling SCLK edge
shift_o  out  1  1-cycle strobe on each shifting SCLK edge
busy_o  out  1  burst in progress
done_o  out  1  1-cycle strobe at normal burst completion

Behaviour:
- Reset values: div_q=0, state IDLE, counters 0, sclk_o=0, sample_o=shift_o=busy_o=done_o=0.
- All outputs are registered.
- Divider register div_q:
  - loaded from div_i when div_stb_i=1, in any state.
  - the active copy is latched at start, so a load during a burst takes effect on the next burst only.
- cpol_i, cpha_i and nb_bits_i are latched when start is accepted.
- While IDLE, sclk_o <= cpol_i each cycle (1-cycle latency).
- States: IDLE, RUN, TAIL.
- IDLE -> RUN:
  - start_i=1 and abort_i=0 accepted at edge T.
  - busy_o=1 from the cycle after T; half-period counter cnt=0; edge counter=0.
  - nb_bits_i=0 goes directly to TAIL instead.
- RUN:
  - cnt increments each cycle.
  - When cnt==div_active: cnt<=0, sclk_o toggles, edge counter increments.
  - A strobe is asserted in the same cycle that sclk_o shows its new value.
  - Odd edges (1,3,..) are leading edges: sample_o if cpha=0, else shift_o.
  - Even edges are trailing edges: shift_o if cpha=0, else sample_o.
  - After edge 2*nb_bits: -> TAIL, cnt=0, sclk_o is back at cpol.
- TAIL:
  - holds for div_active+1 cycles (chip-select hold time).
  - then -> IDLE: busy_o<=0 and done_o<=1 in the same cycle; done_o lasts 1 cycle.
- Total busy_o high time = (2*nb_bits+1)*(div+1) cycles.
- start_i while busy: ignored.
- abort_i:
  - in RUN or TAIL: next cycle is IDLE, busy_o=0, sclk_o=cpol_active, no strobes, no done_o.
  - in IDLE with start_i: abort wins, start is ignored.
- div=0: sclk_o toggles every cycle (fclk/2); strobes are then asserted every cycle.
- Width rules:
  - cnt is DIV_W bits and is compared for equality, never wraps past div.
  - edge counter is BITS_W+1 bits.
- Async reset mid-burst: all state returns to reset values immediately, with no done_o.

Test Plan:
- div=3, cpol=0, cpha=0, nb_bits=2, start -> sclk_o rises 4 cycles after busy_o rises, period 8 cycles, 4 edges; sample_o on rising edges, shift_o on falling edges; busy_o high 20 cycles; done_o one pulse.
- cpol=1, cpha=1, div=0, nb_bits=8 -> sclk_o idles high, toggles every cycle for 16 edges; shift_o on falling edges, sample_o on rising edges; busy_o high 17 cycles.
- div_stb_i with div_i=9 mid-burst (active div=1) -> current burst keeps a 2-cycle half-period; next burst uses a 10-cycle half-period.
- abort_i on cycle 5 of a div=2, nb_bits=4 burst -> busy_o=0 next cycle, sclk_o=cpol, no done_o; a subsequent start runs a full burst.
- start_i together with abort_i in IDLE -> busy_o stays 0. start_i while busy -> burst length unchanged (same edge count).
- nb_bits=0, div=4 -> no sclk_o edges, busy_o high 5 cycles, done_o pulses. rst_i asserted mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/spi_clkgen.sv
// SPI serial-clock generator: programmable half-period, CPOL/CPHA modes and
// N-bit burst framing with start/busy/done/abort handshake.
module spi_clkgen #(
   parameter int DIV_W  = 16,
   parameter int BITS_W = 6
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              div_stb_i,
   input  logic [DIV_W-1:0]  div_i,
   input  logic              cpol_i,
   input  logic              cpha_i,
   input  logic [BITS_W-1:0] nb_bits_i,
   input  logic              start_i,
   input  logic              abort_i,
   output logic              sclk_o,
   output logic              sample_o,
   output logic              shift_o,
   output logic              busy_o,
   output logic              done_o
);

   typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

   state_t            state, state_n;
   logic [DIV_W-1:0]  div_q, div_act, div_act_n;
   logic [DIV_W-1:0]  cnt, cnt_n;
   logic [BITS_W:0]   edge_cnt, edge_n, edge_inc;
   logic [BITS_W-1:0] nb_q, nb_n;
   logic              cpol_q, cpol_n, cpha_q, cpha_n;
   logic              sclk_n, sample_n, shift_n, busy_n, done_n;

   assign edge_inc = edge_cnt + 1'b1;

   always_comb begin
      state_n   = state;
      div_act_n = div_act;
      cnt_n     = cnt;
      edge_n    = edge_cnt;
      nb_n      = nb_q;
      cpol_n    = cpol_q;
      cpha_n    = cpha_q;
      sclk_n    = sclk_o;
      sample_n  = 1'b0;
      shift_n   = 1'b0;
      busy_n    = busy_o;
      done_n    = 1'b0;
      case (state)
         IDLE: begin
            sclk_n = cpol_i;
            // abort has priority over a coincident start
            if (start_i && !abort_i) begin
               div_act_n = div_q;
               cpol_n    = cpol_i;
               cpha_n    = cpha_i;
               nb_n      = nb_bits_i;
               cnt_n     = '0;
               edge_n    = '0;
               busy_n    = 1'b1;
               state_n   = (nb_bits_i == '0) ? TAIL : RUN;
            end
         end
         RUN: begin
            if (abort_i) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               sclk_n  = cpol_q;
            end else if (cnt == div_act) begin
               cnt_n  = '0;
               sclk_n = ~sclk_o;
               edge_n = edge_inc;
               // odd edge count = leading edge
               if (edge_inc[0]) begin
                  sample_n = ~cpha_q;
                  shift_n  = cpha_q;
               end else begin
                  sample_n = cpha_q;
                  shift_n  = ~cpha_q;
               end
               if (edge_inc == {nb_q, 1'b0}) state_n = TAIL;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         TAIL: begin
            if (abort_i) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               sclk_n  = cpol_q;
            end else if (cnt == div_act) begin
               cnt_n   = '0;
               state_n = IDLE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         div_q    <= '0;
         div_act  <= '0;
         cnt      <= '0;
         edge_cnt <= '0;
         nb_q     <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         sclk_o   <= 1'b0;
         sample_o <= 1'b0;
         shift_o  <= 1'b0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
      end else begin
         // the shadow register loads in any state; the active copy only at start
         if (div_stb_i) div_q <= div_i;
         state    <= state_n;
         div_act  <= div_act_n;
         cnt      <= cnt_n;
         edge_cnt <= edge_n;
         nb_q     <= nb_n;
         cpol_q   <= cpol_n;
         cpha_q   <= cpha_n;
         sclk_o   <= sclk_n;
         sample_o <= sample_n;
         shift_o  <= shift_n;
         busy_o   <= busy_n;
         done_o   <= done_n;
      end
   end

endmodule

// File: tb/tb_spi_clkgen.sv
// Directed bench for spi_clkgen: burst timing, modes, reload, abort, reset.
module tb_spi_clkgen;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       div_stb_i = 1'b0;
   logic [15:0] div_i = '0;
   logic       cpol_i = 1'b0;
   logic       cpha_i = 1'b0;
   logic [5:0] nb_bits_i = '0;
   logic       start_i = 1'b0;
   logic       abort_i = 1'b0;
   logic       sclk_o, sample_o, shift_o, busy_o, done_o;

   spi_clkgen #(.DIV_W(16), .BITS_W(6)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .div_stb_i(div_stb_i), .div_i(div_i),
      .cpol_i(cpol_i), .cpha_i(cpha_i), .nb_bits_i(nb_bits_i),
      .start_i(start_i), .abort_i(abort_i), .sclk_o(sclk_o),
      .sample_o(sample_o), .shift_o(shift_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, t_busy = 0;
   int busy_cyc, edges, s_r, s_f, h_r, h_f, bad, done_cnt, first, last, hmin, hmax;
   logic sclk_prev = 1'b0, busy_prev = 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      busy_cyc = 0; edges = 0; s_r = 0; s_f = 0; h_r = 0; h_f = 0;
      bad = 0; done_cnt = 0; first = -1; last = -1; hmin = 999999; hmax = 0;
   endtask

   // advance one cycle and fold the observed outputs into the burst statistics
   task automatic tick();
      logic chg;
      @(negedge clk_i);
      cyc++;
      chg = (sclk_o != sclk_prev);
      if (busy_o && !busy_prev) t_busy = cyc;
      if (busy_o) busy_cyc++;
      if (chg) begin
         edges++;
         if (first < 0) first = cyc - t_busy;
         if (last >= 0) begin
            if (cyc - last < hmin) hmin = cyc - last;
            if (cyc - last > hmax) hmax = cyc - last;
         end
         last = cyc;
      end
      if (sample_o) begin
         if (!chg) bad++;
         else if (sclk_o) s_r++;
         else s_f++;
      end
      if (shift_o) begin
         if (!chg) bad++;
         else if (sclk_o) h_r++;
         else h_f++;
      end
      if (done_o) begin
         done_cnt++;
         if (busy_o) bad++;
      end
      sclk_prev = sclk_o;
      busy_prev = busy_o;
   endtask

   // ab_at / ml_at / rs_at: busy-cycle index at which to abort, reload div=9, restart (0 = never)
   task automatic burst(input int dv, input int ld, input int cp, input int ph,
                        input int nb, input int ab_at, input int ml_at, input int rs_at);
      int n;
      if (ld != 0) begin
         div_i = 16'(dv); div_stb_i = 1'b1; tick(); div_stb_i = 1'b0;
      end
      cpol_i = cp[0]; cpha_i = ph[0]; nb_bits_i = 6'(nb);
      tick(); tick();
      clr();
      start_i = 1'b1; tick(); start_i = 1'b0;
      n = 1;
      while (busy_o && n < 1000) begin
         if (n == ab_at) abort_i = 1'b1;
         if (n == ml_at) begin div_i = 16'd9; div_stb_i = 1'b1; end
         if (n == rs_at) start_i = 1'b1;
         tick();
         abort_i = 1'b0; div_stb_i = 1'b0; start_i = 1'b0;
         n++;
      end
      chk("burst_timeout", int'(n < 1000), 1);
      tick(); tick();
   endtask

   initial begin
      clr();
      tick(); tick();
      chk("reset_outputs", int'({sclk_o, sample_o, shift_o, busy_o, done_o}), 0);
      rst_i = 1'b0;
      tick();

      // mode 0, div=3, 2 bits
      burst(3, 1, 0, 0, 2, 0, 0, 0);
      chk("m0_busy", busy_cyc, 20);
      chk("m0_edges", edges, 4);
      chk("m0_first_edge", first, 4);
      chk("m0_half_min", hmin, 4);
      chk("m0_half_max", hmax, 4);
      chk("m0_sample_rise", s_r, 2);
      chk("m0_shift_fall", h_f, 2);
      chk("m0_wrong_strobe", s_f + h_r + bad, 0);
      chk("m0_done", done_cnt, 1);

      // mode 3, div=0, 8 bits
      div_i = 16'd0; div_stb_i = 1'b1; tick(); div_stb_i = 1'b0;
      cpol_i = 1'b1; tick(); tick();
      chk("m3_idle_high", int'(sclk_o), 1);
      burst(0, 0, 1, 1, 8, 0, 0, 0);
      chk("m3_busy", busy_cyc, 17);
      chk("m3_edges", edges, 16);
      chk("m3_half", hmax, 1);
      chk("m3_sample_rise", s_r, 8);
      chk("m3_shift_fall", h_f, 8);
      chk("m3_wrong_strobe", s_f + h_r + bad, 0);
      chk("m3_done", done_cnt, 1);

      // reload during burst: current stays at div=1, next uses div=9
      burst(1, 1, 0, 0, 3, 0, 3, 0);
      chk("ml_busy", busy_cyc, 14);
      chk("ml_half_min", hmin, 2);
      chk("ml_half_max", hmax, 2);
      burst(9, 0, 0, 0, 1, 0, 0, 0);
      chk("ml_next_busy", busy_cyc, 30);
      chk("ml_next_half", hmin, 10);
      chk("ml_next_first", first, 10);

      // abort on busy cycle 5 of div=2, nb=4, cpol=1
      burst(2, 1, 1, 0, 4, 5, 0, 0);
      chk("ab_busy", busy_cyc, 5);
      chk("ab_sclk_cpol", int'(sclk_o), 1);
      chk("ab_done", done_cnt, 0);
      chk("ab_strobes", s_r + s_f + h_r + h_f, 1);
      burst(2, 0, 1, 0, 4, 0, 0, 0);
      chk("ab_after_busy", busy_cyc, 27);
      chk("ab_after_edges", edges, 8);
      chk("ab_after_sample_fall", s_f, 4);
      chk("ab_after_shift_rise", h_r, 4);
      chk("ab_after_done", done_cnt, 1);

      // start with abort in IDLE is ignored
      clr();
      start_i = 1'b1; abort_i = 1'b1; tick();
      start_i = 1'b0; abort_i = 1'b0; tick(); tick();
      chk("sa_no_busy", busy_cyc, 0);

      // start while busy is ignored (div=1, nb=3, cpha=1)
      burst(1, 1, 0, 1, 3, 0, 0, 3);
      chk("rs_busy", busy_cyc, 14);
      chk("rs_edges", edges, 6);
      chk("rs_shift_rise", h_r, 3);
      chk("rs_sample_fall", s_f, 3);
      chk("rs_done", done_cnt, 1);

      // zero-bit burst
      burst(4, 1, 0, 0, 0, 0, 0, 0);
      chk("nb0_busy", busy_cyc, 5);
      chk("nb0_edges", edges, 0);
      chk("nb0_done", done_cnt, 1);

      // async reset mid-burst with cpol=1
      div_i = 16'd3; div_stb_i = 1'b1; tick(); div_stb_i = 1'b0;
      cpol_i = 1'b1; nb_bits_i = 6'd4; tick(); tick();
      clr();
      start_i = 1'b1; tick(); start_i = 1'b0;
      repeat (5) tick();
      chk("rst_pre_busy", int'(busy_o), 1);
      #1 rst_i = 1'b1;
      #1;
      chk("rst_async_outputs", int'({sclk_o, sample_o, shift_o, busy_o, done_o}), 0);
      tick();
      rst_i = 1'b0;
      tick(); tick();
      chk("rst_no_done", done_cnt, 0);
      chk("rst_idle_busy", int'(busy_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
